// File: rtl/tile_frame_renderer_pkg.sv
// Shared geometry, widths and types for the tile frame renderer.
// The back buffer is XMAX x YMAX pixels, addressed as x*YMAX + y.
package tile_frame_renderer_pkg;

  localparam int unsigned XMAX       = 240;
  localparam int unsigned YMAX       = 264;
  localparam int unsigned TILE_W     = 8;
  localparam int unsigned TILE_SHIFT = $clog2(TILE_W);
  localparam int unsigned TILES_X    = XMAX / TILE_W;
  localparam int unsigned TILES_Y    = YMAX / TILE_W;
  localparam int unsigned FB_PIXELS  = XMAX * YMAX;

  localparam int unsigned X_W        = 8;
  localparam int unsigned Y_W        = 9;
  localparam int unsigned LIN_W      = 16;
  localparam int unsigned MAP_W      = 10;
  localparam int unsigned TILE_IDX_W = 8;
  localparam int unsigned ROM_W      = TILE_IDX_W + 2 * TILE_SHIFT;
  localparam int unsigned PIX_W      = 8;

  localparam logic [LIN_W-1:0] ADDR_IDLE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rend_state_t;

  // Pixel tag carried alongside the tile-map read into the ROM stage.
  typedef struct packed {
    logic [TILE_SHIFT-1:0] x_lo;
    logic [TILE_SHIFT-1:0] y_lo;
    logic [LIN_W-1:0]      lin;
  } pix_tag_t;

endpackage

// File: rtl/tile_frame_renderer_if.sv
// Memory and frame-buffer signals between the renderer and its surroundings.
// master = renderer side, slave = frame buffer / map / pattern ROM side.
interface tile_frame_renderer_if;
  import tile_frame_renderer_pkg::*;

  logic                  write_enable;
  logic [MAP_W-1:0]      map_addr;
  logic [TILE_IDX_W-1:0] map_data;
  logic [ROM_W-1:0]      rom_addr;
  logic [PIX_W-1:0]      rom_data;
  logic [LIN_W-1:0]      addr_write;
  logic [PIX_W-1:0]      data_write;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;

  modport master (
    input  write_enable, map_data, rom_data,
    output map_addr, rom_addr, addr_write, data_write, busy, frame_done, overrun
  );

  modport slave (
    output write_enable, map_data, rom_data,
    input  map_addr, rom_addr, addr_write, data_write, busy, frame_done, overrun
  );

endinterface

// File: rtl/tile_frame_renderer_counter.sv
// Raster sweep counters: y inner loop, x outer loop, linear address and
// tile-row base for the map address, all updated without multipliers.
module pixel_sweep_counter
  import tile_frame_renderer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  output logic [TILE_SHIFT-1:0] x_lo,
  output logic [Y_W-1:0]        y,
  output logic [LIN_W-1:0]      lin,
  output logic [MAP_W-1:0]      map_base,
  output logic                  last
);

  logic [X_W-1:0] x;

  // map_base tracks (x / TILE_W) * TILES_Y, stepping once per tile row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      lin      <= '0;
      map_base <= '0;
    end else if (clear) begin
      x        <= '0;
      y        <= '0;
      lin      <= '0;
      map_base <= '0;
    end else if (advance) begin
      lin <= lin + LIN_W'(1);
      if (y == Y_W'(YMAX - 1)) begin
        y <= '0;
        x <= x + X_W'(1);
        if (x[TILE_SHIFT-1:0] == '1) begin
          map_base <= map_base + MAP_W'(TILES_Y);
        end
      end else begin
        y <= y + Y_W'(1);
      end
    end
  end

  assign x_lo = x[TILE_SHIFT-1:0];
  assign last = (lin == LIN_W'(FB_PIXELS - 1));

endmodule

// File: rtl/tile_frame_renderer.sv
// Sweeps the back buffer once per buffer swap: tile map read, pattern ROM
// read, then one frame-buffer write per clock.
module tile_frame_renderer
  import tile_frame_renderer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  tile_frame_renderer_if.master bus
);

  rend_state_t state_q, state_d;

  logic we_q;
  logic swap;
  logic clear;
  logic flush;
  logic advance;
  logic last;
  logic s0_valid;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ovr_q,  ovr_d;

  logic [TILE_SHIFT-1:0] x_lo;
  logic [Y_W-1:0]        y;
  logic [LIN_W-1:0]      lin;
  logic [MAP_W-1:0]      map_base;

  pix_tag_t         s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic [LIN_W-1:0] s2_lin;
  logic             out_valid;
  logic [LIN_W-1:0] addr_write_q;
  logic [PIX_W-1:0] data_write_q;

  pixel_sweep_counter u_sweep (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .advance  (advance),
    .x_lo     (x_lo),
    .y        (y),
    .lin      (lin),
    .map_base (map_base),
    .last     (last)
  );

  // Either edge of the buffer select starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
    end else begin
      we_q <= bus.write_enable;
    end
  end

  assign swap     = bus.write_enable ^ we_q;
  assign s0_valid = (state_q == RUN);
  assign advance  = s0_valid && !last && !swap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // A swap mid-frame is an upstream fault: flag it, drop in-flight pixels, restart.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    clear   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (swap) begin
          state_d = RUN;
          busy_d  = 1'b1;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (swap) begin
          ovr_d = 1'b1;
          clear = 1'b1;
          flush = 1'b1;
        end else if (last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (swap) begin
          state_d = RUN;
          ovr_d   = 1'b1;
          clear   = 1'b1;
          flush   = 1'b1;
        end else if (out_valid && !s1_valid && !s2_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Stage tags travel with the memory reads; the tag is held while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      s2_lin       <= '0;
      out_valid    <= 1'b0;
      addr_write_q <= ADDR_IDLE;
      data_write_q <= '0;
    end else if (flush) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      out_valid    <= 1'b0;
      addr_write_q <= ADDR_IDLE;
      data_write_q <= '0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_q.x_lo <= x_lo;
        s1_q.y_lo <= y[TILE_SHIFT-1:0];
        s1_q.lin  <= lin;
      end
      s2_valid     <= s1_valid;
      s2_lin       <= s1_q.lin;
      out_valid    <= s2_valid;
      addr_write_q <= s2_valid ? s2_lin : ADDR_IDLE;
      data_write_q <= s2_valid ? bus.rom_data : '0;
    end
  end

  assign bus.map_addr   = map_base + MAP_W'(y[Y_W-1:TILE_SHIFT]);
  assign bus.rom_addr   = {bus.map_data, s1_q.x_lo, s1_q.y_lo};
  assign bus.addr_write = addr_write_q;
  assign bus.data_write = data_write_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_tile_frame_renderer.sv
// Self-checking bench for tile_frame_renderer: random tile map, ramp pattern
// ROM, per-cycle comparison against a frame-timing and pixel model.
module tb_tile_frame_renderer;

  localparam int unsigned XM     = 240;
  localparam int unsigned YM     = 264;
  localparam int unsigned TY     = 33;
  localparam int unsigned NPIX   = XM * YM;
  localparam int unsigned IDLE_A = 32'h0000_FFFF;

  logic clk;
  logic rst_n;

  tile_frame_renderer_if bus ();

  tile_frame_renderer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] map_mem [0:1023];
  logic [7:0] rom_mem [0:16383];
  bit         seen    [0:NPIX-1];

  int          total;
  int          bad;
  int unsigned cur_k;
  int unsigned writes;
  int unsigned dups;

  // Synchronous map and ROM: data is valid one cycle after the address is sampled.
  always @(posedge clk) begin
    bus.map_data <= map_mem[bus.map_addr];
    bus.rom_data <= rom_mem[bus.rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, cur_k, got, exp);
    end
  endtask

  function automatic int unsigned ref_map_idx(input int unsigned a);
    int unsigned x;
    int unsigned y;
    x = a / YM;
    y = a % YM;
    return (x / 8) * TY + (y / 8);
  endfunction

  function automatic int unsigned ref_rom_addr(input int unsigned a);
    int unsigned x;
    int unsigned y;
    x = a / YM;
    y = a % YM;
    return int'(map_mem[ref_map_idx(a)]) * 64 + (x % 8) * 8 + (y % 8);
  endfunction

  function automatic int unsigned ref_data(input int unsigned a);
    return int'(rom_mem[ref_rom_addr(a)]);
  endfunction

  // Cycle k is sampled after edge P0+k, P0 being the edge that saw the swap.
  task automatic frame_cycles(input int unsigned k_end, input bit exp_ovr,
                              input bit toggle_at_end, input bit score);
    int unsigned ea;
    for (int unsigned k = 0; k <= k_end; k++) begin
      @(negedge clk);
      cur_k = k;
      ea = (k >= 3 && k <= NPIX + 2) ? k - 3 : IDLE_A;
      check("addr_write", 32'(bus.addr_write), ea);
      check("data_write", 32'(bus.data_write), (ea == IDLE_A) ? 0 : ref_data(ea));
      check("busy", 32'(bus.busy), 32'(k < NPIX + 3));
      check("frame_done", 32'(bus.frame_done), 32'(k == NPIX + 3));
      check("overrun", 32'(bus.overrun), 32'(exp_ovr));
      if (k < NPIX) check("map_addr", 32'(bus.map_addr), ref_map_idx(k));
      if (k >= 1 && k <= NPIX) check("rom_addr", 32'(bus.rom_addr), ref_rom_addr(k - 1));
      if (score) begin
        if (ea == 0)    check("vec_a0_data", 32'(bus.data_write), 32'h40);
        if (ea == 8)    check("vec_a8_data", 32'(bus.data_write), 32'hC0);
        if (ea == 264)  check("vec_a264_data", 32'(bus.data_write), 32'h48);
        if (ea == 2112) check("vec_a2112_data", 32'(bus.data_write), 32'h40);
        if (k == 8)     check("vec_a8_map", 32'(bus.map_addr), 32'd1);
        if (k == 2112)  check("vec_a2112_map", 32'(bus.map_addr), 32'd33);
        if (bus.addr_write != 16'hFFFF && int'(bus.addr_write) < NPIX) begin
          if (seen[bus.addr_write]) dups++;
          seen[bus.addr_write] = 1'b1;
          writes++;
        end
      end
    end
    if (toggle_at_end) bus.write_enable = ~bus.write_enable;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog k=%0d time limit expired", cur_k);
    $fatal(1, "test done: total=%0d bad=%0d", total, bad + 1);
  end

  initial begin
    int unsigned gap;
    total  = 0;
    bad    = 0;
    cur_k  = 0;
    writes = 0;
    dups   = 0;
    for (int i = 0; i < 1024; i++) map_mem[i] = 8'($urandom);
    map_mem[0]  = 8'd5;
    map_mem[1]  = 8'd7;
    map_mem[33] = 8'd9;
    for (int i = 0; i < 16384; i++) rom_mem[i] = 8'(i);

    rst_n            = 1'b0;
    bus.write_enable = 1'b0;
    @(negedge clk);
    check("rst_addr", 32'(bus.addr_write), IDLE_A);
    check("rst_data", 32'(bus.data_write), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.frame_done), 0);
    check("rst_ovr", 32'(bus.overrun), 0);
    rst_n = 1'b1;

    gap = $urandom_range(2, 9);
    for (int unsigned i = 0; i < gap; i++) begin
      @(negedge clk);
      check("idle_addr", 32'(bus.addr_write), IDLE_A);
      check("idle_busy", 32'(bus.busy), 0);
    end

    // Frame 1 on a rising swap, fully scoreboarded, then a falling swap.
    bus.write_enable = 1'b1;
    frame_cycles(NPIX + 3 + $urandom_range(2, 10), 1'b0, 1'b1, 1'b1);
    check("sb_writes", writes, NPIX);
    check("sb_dups", dups, 0);

    // Frame 2 runs until lin=1000, then a swap arrives while busy.
    frame_cycles(1000, 1'b0, 1'b1, 1'b0);

    // Restarted frame: three idle addresses, then 0,1,2.. with overrun held.
    frame_cycles($urandom_range(500, 3000), 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-frame takes effect without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_addr", 32'(bus.addr_write), IDLE_A);
    check("arst_data", 32'(bus.data_write), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_ovr", 32'(bus.overrun), 0);
    check("arst_done", 32'(bus.frame_done), 0);
    bus.write_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_addr", 32'(bus.addr_write), IDLE_A);
      check("post_rst_busy", 32'(bus.busy), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
